// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg
//   Shared definitions for the byte-serial memory arbiter: transfer size
//   codes, FSM state encodings, the default IO-space marker and the helper
//   that turns a size code into a byte count.
package mem_ctrl_pkg;

    // req_size[1:0] encodings; req_size[2] = 1 selects zero extension
    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;
    localparam logic [1:0] SZ_LINE = 2'b11;

    // Controller FSM states
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_XFER    = 2'd1;
    localparam logic [1:0] ST_WAIT_IO = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    // Default value of addr[17:16] that selects IO space
    localparam logic [1:0] IO_ADDR_HI = 2'b11;

    // Number of bus bytes a request needs. A line write is not a legal
    // request; it is folded into a word write so the bus never runs past
    // the 32-bit write data.
    function automatic logic [4:0] byte_count(input logic [1:0] sz,
                                              input logic       r_nw,
                                              input logic [4:0] max_bytes);
        logic [4:0] n;
        case (sz)
            SZ_HALF: n = 5'd2;
            SZ_BYTE: n = 5'd1;
            SZ_LINE: n = r_nw ? max_bytes : 5'd4;
            default: n = 5'd4;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/mem_arb_grant.sv
// mem_arb_grant
//   Combinational request arbiter. The search for a requesting port starts
//   at ptr when RR_EN is set (round robin) and at port 0 otherwise (fixed
//   priority, lowest index wins).
// Ports:
//   req      in   NUM_PORTS  request vector
//   ptr      in   PW         round-robin start port (ignored when RR_EN=0)
//   gnt_oh   out  NUM_PORTS  one-hot grant
//   gnt_idx  out  PW         binary index of the granted port
//   gnt_any  out  1          some port is granted
module mem_arb_grant #(
    parameter int NUM_PORTS = 2,
    parameter int PW        = 1,
    parameter bit RR_EN     = 1'b0
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [PW-1:0]        ptr,
    output logic [NUM_PORTS-1:0] gnt_oh,
    output logic [PW-1:0]        gnt_idx,
    output logic                 gnt_any
);

    always_comb begin
        int start;
        int p;
        gnt_oh  = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        start   = RR_EN ? int'(ptr) : 0;
        p       = 0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            // rotate the search order so it begins at the start port
            p = start + k;
            if (p >= NUM_PORTS) p = p - NUM_PORTS;
            if (!gnt_any && req[p]) begin
                gnt_any   = 1'b1;
                gnt_oh[p] = 1'b1;
                gnt_idx   = PW'(p);
            end
        end
    end

endmodule

// File: rtl/mem_arbiter_ctrl.sv
// mem_arbiter_ctrl
//   Arbitrates NUM_PORTS clients onto one 8-bit RAM/IO bus and serialises
//   byte/half/word/line transfers, with sign/zero extension of read data,
//   stalling of IO-space writes while the IO buffer is full, and a one-cycle
//   completion pulse per port.
//   Build option: define MEM_ARB_RR_EN for round-robin arbitration; left
//   undefined the arbiter is fixed priority (lowest port index wins).
// Ports:
//   clk_in, rst_in   clock, synchronous active-high reset
//   rdy_in           global enable; low freezes all state and outputs
//   mem_read         RAM/IO read byte, valid the cycle after its address
//   mem_write        write byte
//   mem_addr         byte address (0 when the bus is idle)
//   r_nw_out         1 = read, 0 = write (1 when the bus is idle)
//   io_buffer_full   IO output buffer full
//   req_valid/req_addr/req_wdata/req_r_nw/req_size   per-port request
//   resp_valid       one-hot completion pulse
//   resp_data        extended read result, 0 for writes
//   line_data        full line buffer, valid with resp_valid for line reads
//   busy             a transaction is in flight
//   state_dbg        current FSM state (mem_ctrl_pkg ST_* encodings)
//
// Handshake: a client raises req_valid with its fields and holds all of
// them stable until it sees its own resp_valid bit; that pulse both ends the
// transaction and frees the client to drop or replace its request on the
// following cycle. No request is accepted while busy is high.
module mem_arbiter_ctrl #(
    parameter int         NUM_PORTS  = 2,
    parameter int         MAX_BYTES  = 4,
    parameter logic [1:0] IO_ADDR_HI = mem_ctrl_pkg::IO_ADDR_HI
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic [7:0]               mem_read,
    output logic [7:0]               mem_write,
    output logic [31:0]              mem_addr,
    output logic                     r_nw_out,
    input  logic                     io_buffer_full,
    input  logic [NUM_PORTS-1:0]     req_valid,
    input  logic [NUM_PORTS*32-1:0]  req_addr,
    input  logic [NUM_PORTS*32-1:0]  req_wdata,
    input  logic [NUM_PORTS-1:0]     req_r_nw,
    input  logic [NUM_PORTS*3-1:0]   req_size,
    output logic [NUM_PORTS-1:0]     resp_valid,
    output logic [31:0]              resp_data,
    output logic [8*MAX_BYTES-1:0]   line_data,
    output logic                     busy,
    output logic [1:0]               state_dbg
);
    import mem_ctrl_pkg::*;

    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
`ifdef MEM_ARB_RR_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    logic [1:0]             state_q;
    logic [NUM_PORTS-1:0]   gnt_oh_q;
    logic [PW-1:0]          ptr_q;
    logic [31:0]            addr_q;
    logic [31:0]            wdata_q;
    logic                   r_nw_q;
    logic [2:0]             size_q;
    logic [4:0]             n_q;
    logic [4:0]             idx_q;
    logic                   cap_pend_q;
    logic [4:0]             cap_idx_q;
    logic [8*MAX_BYTES-1:0] line_q;

    logic [NUM_PORTS-1:0]   gnt_oh;
    logic [PW-1:0]          gnt_idx;
    logic                   gnt_any;
    logic [PW-1:0]          ptr_nxt;

    mem_arb_grant #(
        .NUM_PORTS (NUM_PORTS),
        .PW        (PW),
        .RR_EN     (RR_EN)
    ) u_grant (
        .req     (req_valid),
        .ptr     (ptr_q),
        .gnt_oh  (gnt_oh),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    assign ptr_nxt = (gnt_idx == PW'(NUM_PORTS - 1)) ? '0 : gnt_idx + PW'(1);

    // Fields of the granted port
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        sel_r_nw;
    logic [2:0]  sel_size;

    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_r_nw  = 1'b1;
        sel_size  = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (gnt_oh[p]) begin
                sel_addr  = req_addr[32*p +: 32];
                sel_wdata = req_wdata[32*p +: 32];
                sel_r_nw  = req_r_nw[p];
                sel_size  = req_size[3*p +: 3];
            end
        end
    end

    // XFER with idx < n issues a byte, unless it is an IO write blocked by
    // a full buffer; a read at idx == n is the final capture-only cycle.
    logic in_xfer;
    logic more;
    logic io_stall;
    logic issue;

    assign in_xfer  = (state_q == ST_XFER);
    assign more     = (idx_q != n_q);
    assign io_stall = in_xfer && more && !r_nw_q && io_buffer_full &&
                      (addr_q[17:16] == IO_ADDR_HI);
    assign issue    = in_xfer && more && !io_stall;

    assign mem_addr  = issue ? addr_q + {27'd0, idx_q} : 32'd0;
    assign r_nw_out  = issue ? r_nw_q : 1'b1;
    assign mem_write = (issue && !r_nw_q) ? wdata_q[{idx_q[1:0], 3'b000} +: 8] : 8'd0;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= ST_IDLE;
            gnt_oh_q   <= '0;
            ptr_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            r_nw_q     <= 1'b1;
            size_q     <= '0;
            n_q        <= '0;
            idx_q      <= '0;
            cap_pend_q <= 1'b0;
            cap_idx_q  <= '0;
            line_q     <= '0;
        end else if (rdy_in) begin
            // a read byte issued last cycle is on mem_read now
            if (cap_pend_q) line_q[{cap_idx_q, 3'b000} +: 8] <= mem_read;
            cap_pend_q <= issue && r_nw_q;
            cap_idx_q  <= idx_q;

            case (state_q)
                ST_IDLE: begin
                    if (gnt_any) begin
                        gnt_oh_q <= gnt_oh;
                        ptr_q    <= RR_EN ? ptr_nxt : '0;
                        addr_q   <= sel_addr;
                        wdata_q  <= sel_wdata;
                        r_nw_q   <= sel_r_nw;
                        size_q   <= sel_size;
                        n_q      <= byte_count(sel_size[1:0], sel_r_nw, 5'(MAX_BYTES));
                        idx_q    <= '0;
                        line_q   <= '0;
                        state_q  <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (!more) begin
                        state_q <= ST_DONE;
                    end else if (io_stall) begin
                        state_q <= ST_WAIT_IO;
                    end else begin
                        idx_q <= idx_q + 5'd1;
                        // writes finish on the last issue; reads drain one more cycle
                        if (!r_nw_q && (idx_q == n_q - 5'd1)) state_q <= ST_DONE;
                    end
                end
                ST_WAIT_IO: begin
                    if (!io_buffer_full) state_q <= ST_XFER;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign resp_valid = (state_q == ST_DONE) ? gnt_oh_q : '0;
    assign line_data  = line_q;
    assign busy       = (state_q != ST_IDLE);
    assign state_dbg  = state_q;

    always_comb begin
        resp_data = '0;
        if (state_q == ST_DONE && r_nw_q) begin
            case (size_q[1:0])
                SZ_BYTE: resp_data = {{24{line_q[7] & ~size_q[2]}}, line_q[7:0]};
                SZ_HALF: resp_data = {{16{line_q[15] & ~size_q[2]}}, line_q[15:0]};
                default: resp_data = line_q[31:0];
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter_ctrl.sv
module tb_mem_arbiter_ctrl;
  import mem_ctrl_pkg::*;

  localparam int NP = 2;
  localparam int MB = 16;

  logic              clk_in = 1'b0;
  logic              rst_in, rdy_in, io_buffer_full, r_nw_out, busy;
  logic [7:0]        mem_read, mem_write;
  logic [31:0]       mem_addr, resp_data;
  logic [NP-1:0]     req_valid, req_r_nw, resp_valid;
  logic [NP*32-1:0]  req_addr, req_wdata;
  logic [NP*3-1:0]   req_size;
  logic [8*MB-1:0]   line_data;
  logic [1:0]        state_dbg;

  int cmp_cnt = 0;
  int err_cnt = 0;
  int cyc = 0;

  logic [7:0]  ram [0:65535];
  logic [39:0] wr_q[$];
  int          wr_cyc_q[$];
  logic [39:0] exp_q[$];

  mem_arbiter_ctrl #(.NUM_PORTS(NP), .MAX_BYTES(MB)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .r_nw_out(r_nw_out), .io_buffer_full(io_buffer_full),
    .req_valid(req_valid), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_r_nw(req_r_nw), .req_size(req_size), .resp_valid(resp_valid),
    .resp_data(resp_data), .line_data(line_data), .busy(busy),
    .state_dbg(state_dbg)
  );

  // clock / cycle counter
  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  // RAM model: registered read, holds its output while rdy_in is low
  always @(posedge clk_in) begin
    if (rdy_in) begin
      mem_read <= ram[mem_addr[15:0]];
      if (!r_nw_out) ram[mem_addr[15:0]] <= mem_write;
    end
  end

  // bus write log
  always @(negedge clk_in) begin
    if (rdy_in && !r_nw_out) begin
      wr_q.push_back({mem_addr, mem_write});
      wr_cyc_q.push_back(cyc);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task set_req(input int p, input logic [31:0] a, input logic [31:0] wd,
               input logic rnw, input logic [2:0] sz);
    req_addr[32*p +: 32]  = a;
    req_wdata[32*p +: 32] = wd;
    req_r_nw[p]           = rnw;
    req_size[3*p +: 3]    = sz;
    req_valid[p]          = 1'b1;
  endtask

  task wait_resp(input int p, output int lat, output logic [31:0] data);
    lat  = -1;
    data = '0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk_in);
      if (resp_valid[p]) begin
        lat = k;
        data = resp_data;
        req_valid[p] = 1'b0;
        break;
      end
    end
  endtask

  task test_reset;
    rst_in = 1'b1; rdy_in = 1'b1; io_buffer_full = 1'b0;
    req_valid = '0; req_r_nw = '1; req_addr = '0; req_wdata = '0; req_size = '0;
    repeat (3) @(negedge clk_in);
    rst_in = 1'b0;
    @(negedge clk_in);
    cmp_cnt++; if (resp_valid !== 2'b00) begin err_cnt++; $display("FAIL rst_resp_valid: got %b expected 00", resp_valid); end
    cmp_cnt++; if (resp_data !== 32'h0) begin err_cnt++; $display("FAIL rst_resp_data: got %h expected 0", resp_data); end
    cmp_cnt++; if (line_data !== 128'h0) begin err_cnt++; $display("FAIL rst_line_data: got %h expected 0", line_data); end
    cmp_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL rst_busy: got %b expected 0", busy); end
    cmp_cnt++; if (mem_addr !== 32'h0) begin err_cnt++; $display("FAIL rst_mem_addr: got %h expected 0", mem_addr); end
    cmp_cnt++; if (mem_write !== 8'h0) begin err_cnt++; $display("FAIL rst_mem_write: got %h expected 0", mem_write); end
    cmp_cnt++; if (r_nw_out !== 1'b1) begin err_cnt++; $display("FAIL rst_r_nw: got %b expected 1", r_nw_out); end
    cmp_cnt++; if (state_dbg !== ST_IDLE) begin err_cnt++; $display("FAIL rst_state: got %0d expected %0d", state_dbg, ST_IDLE); end
  endtask

  // two simultaneous LBU requests; returns response cycle and data per port
  task run_tie(output int c0, output int c1, output logic [31:0] d0, output logic [31:0] d1,
               output int both);
    c0 = -1; c1 = -1; d0 = '0; d1 = '0; both = 0;
    @(negedge clk_in);
    set_req(0, 32'h100, 32'h0, 1'b1, 3'b110);
    set_req(1, 32'h101, 32'h0, 1'b1, 3'b110);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk_in);
      if (resp_valid == 2'b11) both++;
      if (resp_valid[0] && c0 < 0) begin c0 = k; d0 = resp_data; req_valid[0] = 1'b0; end
      if (resp_valid[1] && c1 < 0) begin c1 = k; d1 = resp_data; req_valid[1] = 1'b0; end
      if (c0 >= 0 && c1 >= 0) break;
    end
  endtask

  task test_priority;
    int c0, c1, both, lat;
    logic [31:0] d0, d1, d;
    run_tie(c0, c1, d0, d1, both);
    cmp_cnt++; if (c0 !== 3 || c1 !== 7) begin err_cnt++; $display("FAIL tie1_order: got p0=%0d p1=%0d expected p0=3 p1=7", c0, c1); end
    cmp_cnt++; if (d0 !== 32'h80 || d1 !== 32'h90) begin err_cnt++; $display("FAIL tie1_data: got %h %h expected 00000080 00000090", d0, d1); end
    cmp_cnt++; if (both !== 0) begin err_cnt++; $display("FAIL tie1_onehot: got %0d double pulses expected 0", both); end
    // port 0 served alone, then another tie
    @(negedge clk_in);
    set_req(0, 32'h100, 32'h0, 1'b1, 3'b110);
    wait_resp(0, lat, d);
    cmp_cnt++; if (lat !== 3) begin err_cnt++; $display("FAIL solo_p0_lat: got %0d expected 3", lat); end
    run_tie(c0, c1, d0, d1, both);
`ifdef MEM_ARB_RR_EN
    cmp_cnt++; if (c1 !== 3 || c0 !== 7) begin err_cnt++; $display("FAIL tie2_order: got p0=%0d p1=%0d expected p0=7 p1=3", c0, c1); end
`else
    cmp_cnt++; if (c0 !== 3 || c1 !== 7) begin err_cnt++; $display("FAIL tie2_order: got p0=%0d p1=%0d expected p0=3 p1=7", c0, c1); end
`endif
  endtask

  task test_load_byte;
    int lat;
    logic [31:0] d;
    @(negedge clk_in);
    set_req(1, 32'h100, 32'h0, 1'b1, 3'b010);
    wait_resp(1, lat, d);
    cmp_cnt++; if (lat !== 3) begin err_cnt++; $display("FAIL lb_lat: got %0d expected 3", lat); end
    cmp_cnt++; if (d !== 32'hFFFFFF80) begin err_cnt++; $display("FAIL lb_data: got %h expected ffffff80", d); end
    cmp_cnt++; if (resp_valid !== 2'b10) begin err_cnt++; $display("FAIL lb_onehot: got %b expected 10", resp_valid); end
    @(negedge clk_in);
    cmp_cnt++; if (resp_valid !== 2'b00 || busy !== 1'b0) begin err_cnt++; $display("FAIL lb_pulse_end: got %b/%b expected 00/0", resp_valid, busy); end
    set_req(1, 32'h100, 32'h0, 1'b1, 3'b110);
    wait_resp(1, lat, d);
    cmp_cnt++; if (lat !== 3 || d !== 32'h00000080) begin err_cnt++; $display("FAIL lbu: got lat=%0d %h expected lat=3 00000080", lat, d); end
    @(negedge clk_in);
    set_req(1, 32'h100, 32'h0, 1'b1, 3'b001);
    wait_resp(1, lat, d);
    cmp_cnt++; if (lat !== 4 || d !== 32'hFFFF9080) begin err_cnt++; $display("FAIL lh: got lat=%0d %h expected lat=4 ffff9080", lat, d); end
    @(negedge clk_in);
    set_req(1, 32'h100, 32'h0, 1'b1, 3'b101);
    wait_resp(1, lat, d);
    cmp_cnt++; if (lat !== 4 || d !== 32'h00009080) begin err_cnt++; $display("FAIL lhu: got lat=%0d %h expected lat=4 00009080", lat, d); end
  endtask

  task test_store_word;
    int lat, t0, n;
    logic [31:0] d;
    @(negedge clk_in);
    wr_q.delete(); wr_cyc_q.delete(); exp_q.delete();
    exp_q.push_back({32'h200, 8'h44}); exp_q.push_back({32'h201, 8'h33});
    exp_q.push_back({32'h202, 8'h22}); exp_q.push_back({32'h203, 8'h11});
    t0 = cyc;
    set_req(1, 32'h200, 32'h11223344, 1'b0, 3'b000);
    wait_resp(1, lat, d);
    cmp_cnt++; if (lat !== 5 || d !== 32'h0) begin err_cnt++; $display("FAIL sw_resp: got lat=%0d %h expected lat=5 0", lat, d); end
    n = wr_q.size();
    cmp_cnt++; if (n !== 4) begin err_cnt++; $display("FAIL sw_count: got %0d expected 4", n); end
    for (int i = 0; i < n && i < 4; i++) begin
      cmp_cnt++; if (wr_q[i] !== exp_q[i] || wr_cyc_q[i] - t0 !== i + 1) begin
        err_cnt++; $display("FAIL sw_byte%0d: got %h at T+%0d expected %h at T+%0d", i, wr_q[i], wr_cyc_q[i] - t0, exp_q[i], i + 1);
      end
    end
    @(negedge clk_in);
    set_req(1, 32'h200, 32'h0, 1'b1, 3'b000);
    wait_resp(1, lat, d);
    cmp_cnt++; if (lat !== 6 || d !== 32'h11223344) begin err_cnt++; $display("FAIL lw: got lat=%0d %h expected lat=6 11223344", lat, d); end
    // line write is carried out as a word write
    @(negedge clk_in);
    wr_q.delete(); wr_cyc_q.delete();
    set_req(0, 32'h400, 32'hAABBCCDD, 1'b0, 3'b011);
    wait_resp(0, lat, d);
    cmp_cnt++; if (lat !== 5 || wr_q.size() !== 4) begin err_cnt++; $display("FAIL line_wr: got lat=%0d writes=%0d expected lat=5 writes=4", lat, wr_q.size()); end
    else begin
      cmp_cnt++; if (wr_q[3] !== {32'h403, 8'hAA}) begin err_cnt++; $display("FAIL line_wr_last: got %h expected 00000403aa", wr_q[3]); end
    end
  endtask

  task test_io_stall;
    int lat, t0;
    logic [31:0] d;
    @(negedge clk_in);
    wr_q.delete(); wr_cyc_q.delete();
    t0 = cyc;
    io_buffer_full = 1'b1;
    set_req(1, 32'h0003_0000, 32'h41, 1'b0, 3'b010);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk_in);
      if (k == 3) begin
        cmp_cnt++; if (state_dbg !== ST_WAIT_IO) begin err_cnt++; $display("FAIL io_wait_state: got %0d expected %0d", state_dbg, ST_WAIT_IO); end
      end
      if (k == 5) io_buffer_full = 1'b0;
      if (resp_valid[1]) begin lat = k; req_valid[1] = 1'b0; break; end
    end
    cmp_cnt++; if (lat !== 7) begin err_cnt++; $display("FAIL io_lat: got %0d expected 7", lat); end
    cmp_cnt++; if (wr_q.size() !== 1) begin err_cnt++; $display("FAIL io_count: got %0d expected 1", wr_q.size()); end
    else begin
      cmp_cnt++; if (wr_q[0] !== {32'h0003_0000, 8'h41} || wr_cyc_q[0] - t0 !== 6) begin
        err_cnt++; $display("FAIL io_write: got %h at T+%0d expected 0003000041 at T+6", wr_q[0], wr_cyc_q[0] - t0);
      end
    end
    // RAM-space write ignores io_buffer_full
    @(negedge clk_in);
    io_buffer_full = 1'b1;
    set_req(1, 32'h205, 32'h77, 1'b0, 3'b010);
    wait_resp(1, lat, d);
    cmp_cnt++; if (lat !== 2) begin err_cnt++; $display("FAIL ram_wr_nostall: got %0d expected 2", lat); end
    // IO-space read is never stalled (0x30000 aliases RAM byte 0 in the model)
    @(negedge clk_in);
    set_req(1, 32'h0003_0000, 32'h0, 1'b1, 3'b110);
    wait_resp(1, lat, d);
    cmp_cnt++; if (lat !== 3 || d !== 32'h41) begin err_cnt++; $display("FAIL io_read: got lat=%0d %h expected lat=3 00000041", lat, d); end
    io_buffer_full = 1'b0;
  endtask

  task test_line_read;
    int lat;
    logic [31:0] d;
    logic [127:0] ld;
    lat = -1; d = '0; ld = '0;
    @(negedge clk_in);
    set_req(0, 32'h1000, 32'h0, 1'b1, 3'b011);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk_in);
      if (k <= 16) begin
        cmp_cnt++; if ({r_nw_out, mem_addr} !== {1'b1, 32'h1000 + 32'(k - 1)}) begin
          err_cnt++; $display("FAIL line_addr%0d: got %b/%h expected 1/%h", k - 1, r_nw_out, mem_addr, 32'h1000 + 32'(k - 1));
        end
      end
      if (resp_valid[0]) begin lat = k; d = resp_data; ld = line_data; req_valid[0] = 1'b0; break; end
    end
    cmp_cnt++; if (lat !== 18) begin err_cnt++; $display("FAIL line_lat: got %0d expected 18", lat); end
    cmp_cnt++; if (d !== 32'hA3A2A1A0) begin err_cnt++; $display("FAIL line_word: got %h expected a3a2a1a0", d); end
    cmp_cnt++; if (ld !== 128'hAFAEADACABAAA9A8A7A6A5A4A3A2A1A0) begin err_cnt++; $display("FAIL line_data: got %h expected afaeadacabaaa9a8a7a6a5a4a3a2a1a0", ld); end
  endtask

  task test_reset_rdy;
    int lat, seen;
    logic [31:0] d;
    @(negedge clk_in);
    set_req(1, 32'h200, 32'h0, 1'b1, 3'b000);
    repeat (2) @(negedge clk_in);
    rst_in = 1'b1; req_valid = '0;
    @(negedge clk_in);
    rst_in = 1'b0;
    cmp_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL abort_busy: got %b expected 0", busy); end
    seen = 0;
    repeat (8) begin @(negedge clk_in); if (resp_valid !== 2'b00) seen++; end
    cmp_cnt++; if (seen !== 0) begin err_cnt++; $display("FAIL abort_resp: got %0d pulses expected 0", seen); end
    set_req(1, 32'h200, 32'h0, 1'b1, 3'b000);
    lat = -1; d = '0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk_in);
      if (k == 3) begin
        cmp_cnt++; if (mem_addr !== 32'h201) begin err_cnt++; $display("FAIL frozen_addr: got %h expected 00000201", mem_addr); end
      end
      if (resp_valid[1]) begin lat = k; d = resp_data; req_valid[1] = 1'b0; break; end
      if (k == 2) rdy_in = 1'b0;
      if (k == 5) rdy_in = 1'b1;
    end
    cmp_cnt++; if (lat !== 9 || d !== 32'h11223344) begin err_cnt++; $display("FAIL rdy_stall: got lat=%0d %h expected lat=9 11223344", lat, d); end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
    ram[16'h0100] = 8'h80;
    ram[16'h0101] = 8'h90;
    for (int i = 0; i < 16; i++) ram[16'h1000 + i] = 8'hA0 + 8'(i);
    mem_read = 8'h00;
    test_reset();
    test_priority();
    test_load_byte();
    test_store_word();
    test_io_stall();
    test_line_read();
    test_reset_rdy();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
